// File: rtl/vga_disp_win.sv
// ============================================================================
// vga_disp_win -- programmable-timing VGA raster generator with a movable,
// resizable framebuffer window.
//
// A free-running hcnt/vcnt raster (stage 0) is decoded into sync, window and
// frame-start flags. Those flags are registered once (stage 1) and then
// registered again together with the framebuffer read data (stage 2). This
// keeps sync and pixel data aligned across the one-clock RAM read.
//
// The framebuffer read address is produced by an incrementing counter, not
// by a multiply. A window pixel at counter state t presents its address on
// addr at t+1. The RAM data for that address is expected on rgb during the
// following clock, and it is captured at the edge that produces cycle t+2.
// That edge is the same one that loads the stage-1 flags for state t into
// stage 2.
//
// Ports:
//   clk25M      in   1       pixel clock
//   reset       in   1       asynchronous, active-high reset
//   rgb         in   PIX_W   framebuffer read data for the address on addr
//   addr        out  ADDR_W  framebuffer read address (registered)
//   VGA_HSYNC   out  1       horizontal sync (registered, polarity SYNC_POL)
//   VGA_VSYNC   out  1       vertical sync (registered, polarity SYNC_POL)
//   VGA_D       out  12      pixel colour {R,G,B} (registered)
//   frame_start out  1       pulse with the first active pixel of a frame
//   frame_cnt   out  16      frames started since reset, wraps at 65535
//
// Optional build macro: VGA_DISP_WIN_BORDER_EN
//   When defined, active pixels outside the window that lie in the two
//   outermost columns or rows of the active area show BORDER_COLOR.
//   Window pixels take priority over border pixels. When the macro is
//   undefined, those pixels are black and BORDER_COLOR has no effect.
// ============================================================================
module vga_disp_win #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          SYNC_POL     = 0,
    parameter int          WIN_X        = 192,
    parameter int          WIN_Y        = 112,
    parameter int          WIN_W        = 256,
    parameter int          WIN_H        = 256,
    parameter int          ADDR_W       = 16,
    parameter int          PIX_W        = 1,
    parameter logic [11:0] FG_COLOR     = 12'hfff,
    parameter logic [11:0] BORDER_COLOR = 12'hf00
) (
    input  logic              clk25M,
    input  logic              reset,
    input  logic [PIX_W-1:0]  rgb,
    output logic [ADDR_W-1:0] addr,
    output logic              VGA_HSYNC,
    output logic              VGA_VSYNC,
    output logic [11:0]       VGA_D,
    output logic              frame_start,
    output logic [15:0]       frame_cnt
);

    // ------------------------------------------------------------------------
    // Derived timing constants. The counter widths can hold H_TOTAL and
    // V_TOTAL themselves. A sync pulse that ends exactly at the line or frame
    // end therefore still compares correctly.
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL + 1);
    localparam int VCW     = $clog2(V_TOTAL + 1);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_BEG   = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCW-1:0] WX_BEG   = HCW'(WIN_X);
    localparam logic [HCW-1:0] WX_END   = HCW'(WIN_X + WIN_W);

    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] VS_BEG   = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0] WY_BEG   = VCW'(WIN_Y);
    localparam logic [VCW-1:0] WY_END   = VCW'(WIN_Y + WIN_H);

    localparam logic           SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

`ifdef VGA_DISP_WIN_BORDER_EN
    localparam logic [HCW-1:0] H_EDGE_LO  = HCW'(2);
    localparam logic [HCW-1:0] H_EDGE_HI  = HCW'(H_ACTIVE - 2);
    localparam logic [VCW-1:0] V_EDGE_LO  = VCW'(2);
    localparam logic [VCW-1:0] V_EDGE_HI  = VCW'(V_ACTIVE - 2);
    localparam logic [11:0]    EDGE_COLOR = BORDER_COLOR;
`else
    // Border disabled: the colour is masked to black, so the edge path is
    // constant and optimises away.
    localparam logic [11:0]    EDGE_COLOR = BORDER_COLOR & 12'h000;
`endif

    // ------------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------------
    if ((WIN_X + WIN_W > H_ACTIVE) || (WIN_Y + WIN_H > V_ACTIVE)) begin : g_err_win
        $error("vga_disp_win: window is clipped by the active area");
    end
    if ((PIX_W != 1) && (PIX_W != 12)) begin : g_err_pix
        $error("vga_disp_win: PIX_W must be 1 or 12");
    end
    if ((64'd1 << ADDR_W) < (64'(WIN_W) * 64'(WIN_H))) begin : g_err_addr
        $error("vga_disp_win: ADDR_W too small for WIN_W*WIN_H");
    end

    // ------------------------------------------------------------------------
    // Stage 0: raster counters and their decode
    // ------------------------------------------------------------------------
    logic [HCW-1:0]    r_hcnt;
    logic [VCW-1:0]    r_vcnt;
    logic [ADDR_W-1:0] r_next_addr;

    logic w_h_last;
    logic w_v_last;
    logic w_de;
    logic w_win;
    logic w_hs;
    logic w_vs;
    logic w_first;
    logic w_edge;

    // Stage-0 decode of the current raster position
    always_comb begin
        w_h_last = (r_hcnt == H_LAST);
        w_v_last = (r_vcnt == V_LAST);
        w_de     = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
        w_win    = w_de &&
                   (r_hcnt >= WX_BEG) && (r_hcnt < WX_END) &&
                   (r_vcnt >= WY_BEG) && (r_vcnt < WY_END);
        w_hs     = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
        w_vs     = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
        w_first  = (r_hcnt == {HCW{1'b0}}) && (r_vcnt == {VCW{1'b0}});
`ifdef VGA_DISP_WIN_BORDER_EN
        w_edge   = w_de && !w_win &&
                   ((r_hcnt < H_EDGE_LO) || (r_hcnt >= H_EDGE_HI) ||
                    (r_vcnt < V_EDGE_LO) || (r_vcnt >= V_EDGE_HI));
`else
        w_edge   = 1'b0;
`endif
    end

    // Horizontal and vertical raster counters; vcnt steps on the last
    // clock of each line.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            r_hcnt <= {HCW{1'b0}};
            r_vcnt <= {VCW{1'b0}};
        end else if (w_h_last) begin
            r_hcnt <= {HCW{1'b0}};
            r_vcnt <= w_v_last ? {VCW{1'b0}} : (r_vcnt + VCW'(1));
        end else begin
            r_hcnt <= r_hcnt + HCW'(1);
            r_vcnt <= r_vcnt;
        end
    end

    // Framebuffer address. r_next_addr counts the window pixels already
    // scanned this frame. addr captures it on window pixels and holds it
    // everywhere else, so the RAM input stays quiet outside the window.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            r_next_addr <= {ADDR_W{1'b0}};
            addr        <= {ADDR_W{1'b0}};
        end else begin
            if (w_h_last && w_v_last) begin
                r_next_addr <= {ADDR_W{1'b0}};
            end else if (w_win) begin
                r_next_addr <= r_next_addr + ADDR_W'(1);
            end else begin
                r_next_addr <= r_next_addr;
            end
            if (w_win) begin
                addr <= r_next_addr;
            end else begin
                addr <= addr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: registered decode, one clock behind the counters. This is the
    // same latency as addr.
    // ------------------------------------------------------------------------
    logic r_hs1;
    logic r_vs1;
    logic r_win1;
    logic r_first1;
    logic r_edge1;

    // Stage-1 flag registers
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_win1   <= 1'b0;
            r_first1 <= 1'b0;
            r_edge1  <= 1'b0;
        end else begin
            r_hs1    <= w_hs;
            r_vs1    <= w_vs;
            r_win1   <= w_win;
            r_first1 <= w_first;
            r_edge1  <= w_edge;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: pixel colour selection and output registers
    // ------------------------------------------------------------------------
    logic [11:0] w_pix;
    logic [11:0] w_d;

    if (PIX_W == 1) begin : g_mono
        // Monochrome framebuffer: one bit selects the foreground colour
        assign w_pix = rgb[0] ? FG_COLOR : 12'h000;
    end else begin : g_colour
        assign w_pix = rgb;
    end

    // Colour priority: window, then screen-edge border, otherwise black.
    // Blanking is never inside the window or the border, so it stays black.
    always_comb begin
        w_d = 12'h000;
        if (r_win1) begin
            w_d = w_pix;
        end else if (r_edge1) begin
            w_d = EDGE_COLOR;
        end else begin
            w_d = 12'h000;
        end
    end

    // Output registers; frame_cnt steps together with frame_start
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            VGA_HSYNC   <= ~SYNC_ON;
            VGA_VSYNC   <= ~SYNC_ON;
            VGA_D       <= 12'h000;
            frame_start <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            VGA_HSYNC   <= r_hs1 ? SYNC_ON : ~SYNC_ON;
            VGA_VSYNC   <= r_vs1 ? SYNC_ON : ~SYNC_ON;
            VGA_D       <= w_d;
            frame_start <= r_first1;
            frame_cnt   <= r_first1 ? (frame_cnt + 16'd1) : frame_cnt;
        end
    end

endmodule

// File: tb/tb_vga_disp_win.sv
`timescale 1ns/1ps
// Testbench for vga_disp_win. It uses two reduced-timing instances so that
// several whole frames fit in a short run:
//   u_dut1: monochrome (PIX_W=1), active-low sync, RAM data = addr[0]
//   u_dut2: 12-bit colour, active-high sync, RAM = random colour table,
//           and a window that touches the left and right active edges.
// The reference model computes each output from the raster position, using
// a closed-form count of window pixels.
module tb_vga_disp_win;

    typedef struct packed {
        int ha; int hfp; int hsy; int hbp;
        int va; int vfp; int vsy; int vbp;
        int wx; int wy; int ww; int wh;
    } cfg_t;

    typedef struct {
        bit hs; bit vs; bit win; bit brd; bit first;
        int idx; int addr;
    } pos_t;

    typedef struct {
        int x; int y; logic [11:0] vga; int addr;
    } vec_t;

    localparam cfg_t C1 = '{16, 2, 3, 3, 12, 1, 2, 2, 4, 3, 8, 6};
    localparam cfg_t C2 = '{20, 1, 4, 2, 10, 1, 3, 1, 0, 2, 20, 8};
    localparam int HT1 = 24, VT1 = 17, FT1 = HT1 * VT1;
    localparam int HT2 = 27, VT2 = 15, FT2 = HT2 * VT2;
    localparam int NRUN = 2 * FT1 + 12;
`ifdef VGA_DISP_WIN_BORDER_EN
    localparam bit BRD_EN = 1'b1;
`else
    localparam bit BRD_EN = 1'b0;
`endif
    localparam logic [11:0] BRD_EXP = BRD_EN ? 12'hf00 : 12'h000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [0:0]  rgb1;
    logic [5:0]  addr1;
    logic        hs1, vs1, fs1;
    logic [11:0] vga1;
    logic [15:0] fc1;
    logic [11:0] rgb2;
    logic [7:0]  addr2;
    logic        hs2, vs2, fs2;
    logic [11:0] vga2;
    logic [15:0] fc2;

    logic [11:0] mem2 [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        hist_hs1 [0:NRUN-1];
    logic        hist_vs1 [0:NRUN-1];
    logic        hist_fs1 [0:NRUN-1];
    logic [11:0] hist_vga1[0:NRUN-1];
    logic [5:0]  hist_addr1[0:NRUN-1];
    logic [15:0] hist_fc1 [0:NRUN-1];
    logic        hist_hs2 [0:NRUN-1];
    logic        hist_vs2 [0:NRUN-1];
    logic [15:0] hist_fc2 [0:NRUN-1];

    always #5 clk = ~clk;

    // Framebuffer models: combinational read of the registered address
    assign rgb1 = addr1[0];
    assign rgb2 = mem2[addr2];

    vga_disp_win #(
        .H_ACTIVE(C1.ha), .H_FP(C1.hfp), .H_SYNC(C1.hsy), .H_BP(C1.hbp),
        .V_ACTIVE(C1.va), .V_FP(C1.vfp), .V_SYNC(C1.vsy), .V_BP(C1.vbp),
        .SYNC_POL(0), .WIN_X(C1.wx), .WIN_Y(C1.wy), .WIN_W(C1.ww), .WIN_H(C1.wh),
        .ADDR_W(6), .PIX_W(1), .FG_COLOR(12'hfff), .BORDER_COLOR(12'hf00)
    ) u_dut1 (
        .clk25M(clk), .reset(reset), .rgb(rgb1), .addr(addr1),
        .VGA_HSYNC(hs1), .VGA_VSYNC(vs1), .VGA_D(vga1),
        .frame_start(fs1), .frame_cnt(fc1)
    );

    vga_disp_win #(
        .H_ACTIVE(C2.ha), .H_FP(C2.hfp), .H_SYNC(C2.hsy), .H_BP(C2.hbp),
        .V_ACTIVE(C2.va), .V_FP(C2.vfp), .V_SYNC(C2.vsy), .V_BP(C2.vbp),
        .SYNC_POL(1), .WIN_X(C2.wx), .WIN_Y(C2.wy), .WIN_W(C2.ww), .WIN_H(C2.wh),
        .ADDR_W(8), .PIX_W(12), .FG_COLOR(12'hfff), .BORDER_COLOR(12'hf00)
    ) u_dut2 (
        .clk25M(clk), .reset(reset), .rgb(rgb2), .addr(addr2),
        .VGA_HSYNC(hs2), .VGA_VSYNC(vs2), .VGA_D(vga2),
        .frame_start(fs2), .frame_cnt(fc2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Raster position s (clocks since reset release) -> expected attributes
    function automatic pos_t scan(input cfg_t c, input int s);
        pos_t p;
        int ht, vt, h, v, full, part, cnt;
        ht = c.ha + c.hfp + c.hsy + c.hbp;
        vt = c.va + c.vfp + c.vsy + c.vbp;
        h = s % ht;
        v = (s / ht) % vt;
        p.hs    = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsy);
        p.vs    = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsy);
        p.win   = (h >= c.wx) && (h < c.wx + c.ww) && (v >= c.wy) && (v < c.wy + c.wh);
        p.brd   = (h < c.ha) && (v < c.va) && !p.win &&
                  ((h < 2) || (h >= c.ha - 2) || (v < 2) || (v >= c.va - 2));
        p.first = (s % (ht * vt)) == 0;
        p.idx   = (v - c.wy) * c.ww + (h - c.wx);
        // window pixels scanned so far in this frame, including this one
        full = (v < c.wy) ? 0 : ((v - c.wy < c.wh) ? (v - c.wy) : c.wh);
        part = 0;
        if ((v >= c.wy) && (v < c.wy + c.wh)) begin
            part = h - c.wx + 1;
            if (part < 0) part = 0;
            if (part > c.ww) part = c.ww;
        end
        cnt = full * c.ww + part;
        p.addr = (cnt > 0) ? cnt - 1 : ((s >= ht * vt) ? c.ww * c.wh - 1 : 0);
        return p;
    endfunction

    task automatic check_all();
        pos_t q;
        logic [11:0] ev;
        // instance 1
        if (cyc >= 2) q = scan(C1, cyc - 2); else q = '{default: 0};
        ev = q.win ? (q.idx[0] ? 12'hfff : 12'h000) : ((BRD_EN && q.brd) ? 12'hf00 : 12'h000);
        chk("hsync1", hs1, q.hs ? 1'b0 : 1'b1);
        chk("vsync1", vs1, q.vs ? 1'b0 : 1'b1);
        chk("vga1", vga1, ev);
        chk("fstart1", fs1, q.first);
        chk("fcnt1", fc1, (cyc >= 2) ? (((cyc - 2) / FT1 + 1) % 65536) : 0);
        if (cyc >= 1) q = scan(C1, cyc - 1); else q = '{default: 0};
        chk("addr1", addr1, q.addr % 64);
        // instance 2
        if (cyc >= 2) q = scan(C2, cyc - 2); else q = '{default: 0};
        ev = q.win ? mem2[q.idx] : ((BRD_EN && q.brd) ? 12'hf00 : 12'h000);
        chk("hsync2", hs2, q.hs ? 1'b1 : 1'b0);
        chk("vsync2", vs2, q.vs ? 1'b1 : 1'b0);
        chk("vga2", vga2, ev);
        chk("fstart2", fs2, q.first);
        chk("fcnt2", fc2, (cyc >= 2) ? (((cyc - 2) / FT2 + 1) % 65536) : 0);
        if (cyc >= 1) q = scan(C2, cyc - 1); else q = '{default: 0};
        chk("addr2", addr2, q.addr % 256);
    endtask

    task automatic run_cycles(input int n, input bit rec);
        for (int i = 0; i < n; i++) begin
            check_all();
            if (rec && cyc < NRUN) begin
                hist_hs1[cyc] = hs1;  hist_vs1[cyc] = vs1;  hist_fs1[cyc] = fs1;
                hist_vga1[cyc] = vga1; hist_addr1[cyc] = addr1; hist_fc1[cyc] = fc1;
                hist_hs2[cyc] = hs2;  hist_vs2[cyc] = vs2;  hist_fc2[cyc] = fc2;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr1"}, addr1, 6'd0);
        chk({tag, "_vga1"}, vga1, 12'h000);
        chk({tag, "_hs1"}, hs1, 1'b1);
        chk({tag, "_vs1"}, vs1, 1'b1);
        chk({tag, "_fs1"}, fs1, 1'b0);
        chk({tag, "_fc1"}, fc1, 16'd0);
        chk({tag, "_addr2"}, addr2, 8'd0);
        chk({tag, "_vga2"}, vga2, 12'h000);
        chk({tag, "_hs2"}, hs2, 1'b0);
        chk({tag, "_vs2"}, vs2, 1'b0);
        chk({tag, "_fs2"}, fs2, 1'b0);
        chk({tag, "_fc2"}, fc2, 16'd0);
    endtask

    // Watchdog: the run is a fixed number of clocks, so this only fires on a
    // broken simulation.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        int cnt, base, r;

        // Probe pixels of instance 1: {x, y, VGA_D, addr (-1 = not probed)}
        tbl[0]  = '{4,  3,  12'h000, 0};
        tbl[1]  = '{5,  3,  12'hfff, 1};
        tbl[2]  = '{11, 3,  12'hfff, 7};
        tbl[3]  = '{4,  4,  12'h000, 8};
        tbl[4]  = '{5,  4,  12'hfff, 9};
        tbl[5]  = '{11, 8,  12'hfff, 47};
        tbl[6]  = '{3,  3,  12'h000, -1};
        tbl[7]  = '{12, 3,  12'h000, -1};
        tbl[8]  = '{20, 5,  12'h000, -1};
        tbl[9]  = '{6,  14, 12'h000, -1};
        tbl[10] = '{0,  0,  BRD_EXP, -1};
        tbl[11] = '{15, 11, BRD_EXP, -1};
        tbl[12] = '{1,  6,  BRD_EXP, -1};

        for (int i = 0; i < 256; i++) mem2[i] = 12'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("rst");

        // Release and run two full frames against the model
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc = 0;
        run_cycles(NRUN, 1'b1);

        // Table of probe pixels; VGA_D lags the counter by 2, addr by 1
        for (int i = 0; i < 13; i++) begin
            base = tbl[i].y * HT1 + tbl[i].x;
            chk("tbl_vga", hist_vga1[base + 2], tbl[i].vga);
            if (tbl[i].addr >= 0) chk("tbl_addr", hist_addr1[base + 1], tbl[i].addr);
        end

        // Sync pulse widths per line and per frame
        for (int l = 0; l < 2 * VT1; l++) begin
            cnt = 0;
            for (int k = 2 + l * HT1; k < 2 + (l + 1) * HT1; k++) if (hist_hs1[k] == 1'b0) cnt++;
            chk("hs1_width", cnt, C1.hsy);
        end
        for (int f = 0; f < 2; f++) begin
            cnt = 0;
            for (int k = 2 + f * FT1; k < 2 + (f + 1) * FT1; k++) if (hist_vs1[k] == 1'b0) cnt++;
            chk("vs1_width", cnt, C1.vsy * HT1);
        end
        for (int l = 0; l < 2 * VT2; l++) begin
            cnt = 0;
            for (int k = 2 + l * HT2; k < 2 + (l + 1) * HT2; k++) if (hist_hs2[k] == 1'b1) cnt++;
            chk("hs2_width", cnt, C2.hsy);
        end
        for (int f = 0; f < 2; f++) begin
            cnt = 0;
            for (int k = 2 + f * FT2; k < 2 + (f + 1) * FT2; k++) if (hist_vs2[k] == 1'b1) cnt++;
            chk("vs2_width", cnt, C2.vsy * HT2);
        end
        chk("fcnt1_2frames", hist_fc1[2 * FT1 + 1], 16'd2);
        chk("fcnt2_2frames", hist_fc2[2 * FT2 + 1], 16'd2);

        // Mid-frame reset at a random point: asynchronous clear, then the
        // first frame_start comes 2 clocks after release
        r = $urandom_range(380, 60);
        run_cycles(r, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc = 0;
        run_cycles(40, 1'b1);
        chk("rel_fs_k1", hist_fs1[1], 1'b0);
        chk("rel_fs_k2", hist_fs1[2], 1'b1);
        chk("rel_fc_k2", hist_fc1[2], 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
